// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
// Shared definitions for the data SRAM responder:
//   - size_e     : access size encodings carried on data_size
//   - legal range limits for RESP_LAT and MAX_OUT
//   - LFSR_SEED  : reset value of the optional stall-injection LFSR
//   - lfsr_next  : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

    typedef enum logic [2:0] {
        SIZE_B = 3'd0,
        SIZE_H = 3'd1,
        SIZE_W = 3'd2
    } size_e;

    localparam int RESP_LAT_MIN = 1;
    localparam int RESP_LAT_MAX = 4;
    localparam int MAX_OUT_MIN  = 1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Shift left, feeding back the XOR of taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_shift_pipe.sv
// -----------------------------------------------------------------------------
// data_sram_responder_resp_shift_pipe
// RESP_LAT-deep shift register of {valid, is_read} plus the read word.
// Stage 0 is loaded on the accept edge; the SRAM word appears one cycle later
// and is captured into stage 1, then carried with its entry to the last stage.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : a request was accepted this cycle
//   load_is_read    : the accepted request is a read
//   ram_rdata [32]  : SRAM read data (valid one cycle after a read access)
//   resp_valid      : last stage holds a response
//   resp_rdata [32] : read word of the last stage, zero for write entries
// -----------------------------------------------------------------------------
module data_sram_responder_resp_shift_pipe #(
    parameter int RESP_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        load_is_read,
    input  logic [31:0] ram_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);

    logic [RESP_LAT-1:0] valid_q;
    logic [RESP_LAT-1:0] is_read_q;

    // Control shift chain; reset empties it so in-flight responses are lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            is_read_q <= '0;
        end else begin
            valid_q[0]   <= load;
            is_read_q[0] <= load && load_is_read;
            for (int i = 1; i < RESP_LAT; i++) begin
                valid_q[i]   <= valid_q[i-1];
                is_read_q[i] <= is_read_q[i-1];
            end
        end
    end

    assign resp_valid = valid_q[RESP_LAT-1];

    generate
        if (RESP_LAT == 1) begin : g_lat1
            // Capture and return coincide: the SRAM output register is the
            // response register, so its word is forwarded for read entries.
            assign resp_rdata = (valid_q[0] && is_read_q[0]) ? ram_rdata : '0;
        end else begin : g_latn
            logic [31:0] rdata_q [1:RESP_LAT-1];

            // Read word captured one cycle after accept, then shifted along.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 1; i < RESP_LAT; i++) begin
                        rdata_q[i] <= '0;
                    end
                end else begin
                    rdata_q[1] <= (valid_q[0] && is_read_q[0]) ? ram_rdata : '0;
                    for (int i = 2; i < RESP_LAT; i++) begin
                        rdata_q[i] <= rdata_q[i-1];
                    end
                end
            end

            assign resp_rdata = is_read_q[RESP_LAT-1] ? rdata_q[RESP_LAT-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
// Responder end of the SRAM-like CPU data interface. Accepts requests, drives a
// 1-cycle-latency synchronous data SRAM, and returns one in-order response per
// accepted request exactly RESP_LAT cycles after acceptance.
// Parameters:
//   RESP_LAT : accept-to-data_ok latency in cycles (1..4)
//   MAX_OUT  : max accepted-but-unanswered requests (1..RESP_LAT)
//   AW       : SRAM word-address width (ram_addr = data_addr[AW+1:2], AW <= 30)
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   data_req/wr/wstrb/addr/size/wdata : request from the execute stage
//   data_addr_ok                 : request accepted when data_req is also high
//   data_data_ok, data_rdata     : response strobe and read word (0 for writes)
//   ram_en/wen/addr/wdata        : SRAM access, combinational from the request
//   ram_rdata                    : SRAM read word, one cycle after a read
// Configuration:
//   DATA_SRAM_RESP_STALL_EN : when defined, a 16-bit LFSR randomly withholds
//                             data_addr_ok (about one cycle in four).
// -----------------------------------------------------------------------------
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int RESP_LAT = 2,
    parameter int MAX_OUT  = 2,
    parameter int AW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [3:0]    data_wstrb,
    input  logic [31:0]   data_addr,
    input  logic [2:0]    data_size,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             ret;
    logic             stall_inj;
    logic             resp_valid;
    logic [31:0]      resp_rdata;

    generate
        if (RESP_LAT < RESP_LAT_MIN || RESP_LAT > RESP_LAT_MAX ||
            MAX_OUT < MAX_OUT_MIN || MAX_OUT > RESP_LAT) begin : g_bad_cfg
            $error("data_sram_responder: RESP_LAT/MAX_OUT out of range");
        end
    endgenerate

`ifdef DATA_SRAM_RESP_STALL_EN
    logic [15:0] lfsr;

    // Free-running LFSR; stalls only gate acceptance, never the response timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign stall_inj = (lfsr[1:0] == 2'b00);
`else
    assign stall_inj = 1'b0;
`endif

    assign data_addr_ok = !reset && (cnt < CNT_W'(MAX_OUT)) && !stall_inj;
    assign accept       = data_req && data_addr_ok;

    assign ram_en    = accept;
    assign ram_wen   = (accept && data_wr) ? data_wstrb : 4'b0000;
    assign ram_addr  = data_addr[AW+1:2];
    assign ram_wdata = data_wdata;

    data_sram_responder_resp_shift_pipe #(
        .RESP_LAT (RESP_LAT)
    ) u_resp_pipe (
        .clk          (clk),
        .reset        (reset),
        .load         (accept),
        .load_is_read (!data_wr),
        .ram_rdata    (ram_rdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata)
    );

    // Fixed latency means the pipe's last stage is exactly one response per cycle.
    assign ret          = resp_valid;
    assign data_data_ok = !reset && resp_valid;
    assign data_rdata   = reset ? '0 : resp_rdata;

    // Outstanding counter: accept and return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({accept, ret})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Simulation-only sanity checks on the interface and the counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(ret && !accept && cnt == '0));
            assert (!accept || (data_size <= SIZE_W && data_addr[1:0] == 2'b00));
        end
    end

    logic unused_bits;
    assign unused_bits = ^{data_addr[31:AW+2], data_addr[1:0], data_size};

endmodule

// File: tb/tb_data_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_data_sram_responder
// Self-checking bench for data_sram_responder. A behavioural 1-cycle SRAM sits
// on the ram_* side; a scoreboard queue holds the expected due cycle and read
// word of every accepted request, and a monitor compares on the falling edge.
// With DATA_SRAM_RESP_STALL_EN defined, the expected data_addr_ok also
// follows an independent LFSR model.
// -----------------------------------------------------------------------------
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    localparam int RESP_LAT = 2;
    localparam int MAX_OUT  = 2;
    localparam int AW       = 16;

`ifdef DATA_SRAM_RESP_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_wstrb;
    logic [31:0]   data_addr;
    logic [2:0]    data_size;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          ram_en;
    logic [3:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model_mem [int];
    logic [31:0] sram_mem  [int];
    int          m_cnt = 0;
    logic [15:0] m_lfsr;

    data_sram_responder #(
        .RESP_LAT (RESP_LAT),
        .MAX_OUT  (MAX_OUT),
        .AW       (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ram_en       (ram_en),
        .ram_wen      (ram_wen),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous SRAM with byte write enables.
    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen != 4'b0000) begin
                logic [31:0] word;
                word = sram_mem.exists(int'(ram_addr)) ? sram_mem[int'(ram_addr)] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (ram_wen[b]) word[8*b +: 8] = ram_wdata[8*b +: 8];
                end
                sram_mem[int'(ram_addr)] = word;
            end else begin
                ram_rdata <= sram_mem.exists(int'(ram_addr)) ? sram_mem[int'(ram_addr)] : 32'h0;
            end
        end
    end

    // Independent stall model: Fibonacci LFSR, taps 16,14,13,11.
    always @(posedge clk) begin
        if (reset) m_lfsr <= LFSR_SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [2:0] sizeFor(input logic [3:0] strb);
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_B;
            4'b0011, 4'b1100:                   return SIZE_H;
            default:                            return SIZE_W;
        endcase
    endfunction

    // Monitor and scoreboard, sampled away from the rising edge.
    always @(negedge clk) begin
        logic ret_exp;
        logic ok_exp;
        logic acc;
        exp_t e;
        if (reset) begin
            checkOutput("rst_data_ok", 32'(data_data_ok), 32'h0);
            checkOutput("rst_addr_ok", 32'(data_addr_ok), 32'h0);
            checkOutput("rst_ram_en",  32'(ram_en),       32'h0);
            checkOutput("rst_rdata",   data_rdata,        32'h0);
            sb.delete();
            m_cnt = 0;
        end else begin
            ret_exp = (sb.size() > 0) && (sb[0].due == cyc);
            checkOutput("data_ok", 32'(data_data_ok), 32'(ret_exp));
            if (ret_exp) begin
                e = sb.pop_front();
                checkOutput("rdata", data_rdata, e.rdata);
            end
            ok_exp = (m_cnt < MAX_OUT) && !(STALL_EN && m_lfsr[1:0] == 2'b00);
            checkOutput("addr_ok", 32'(data_addr_ok), 32'(ok_exp));
            acc = data_req && data_addr_ok;
            checkOutput("ram_en", 32'(ram_en), 32'(acc));
            if (acc) begin
                int key;
                key = int'(data_addr[AW+1:2]);
                checkOutput("ram_addr", 32'(ram_addr), 32'(data_addr[AW+1:2]));
                checkOutput("ram_wen",  32'(ram_wen),  32'(data_wr ? data_wstrb : 4'b0000));
                e.due = cyc + RESP_LAT;
                if (data_wr) begin
                    logic [31:0] word;
                    word = model_mem.exists(key) ? model_mem[key] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (data_wstrb[b]) word[8*b +: 8] = data_wdata[8*b +: 8];
                    end
                    model_mem[key] = word;
                    e.rdata = 32'h0;
                end else begin
                    e.rdata = model_mem.exists(key) ? model_mem[key] : 32'h0;
                end
                sb.push_back(e);
            end else begin
                checkOutput("ram_wen_idle", 32'(ram_wen), 32'h0);
            end
            m_cnt = m_cnt + (acc ? 1 : 0) - (ret_exp ? 1 : 0);
        end
    end

    // Present one request and hold it until accepted (bounded); req stays high.
    task automatic applyStimulus(input logic wr, input logic [3:0] strb,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int  waited = 0;
        bit  done   = 0;
        data_req   = 1'b1;
        data_wr    = wr;
        data_wstrb = wr ? strb : 4'b0000;
        data_addr  = addr;
        data_size  = wr ? sizeFor(strb) : SIZE_W;
        data_wdata = wdata;
        while (!done) begin
            @(negedge clk);
            done = data_addr_ok;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 64) begin
                checkOutput("accept_timeout", 32'h0, 32'h1);
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'b0000;
        data_wdata = 32'h0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'b0000;
        data_addr  = 32'h0;
        data_size  = SIZE_W;
        data_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] idle after reset");
        idle(5);

        $display("[TB] word write then read");
        applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344);
        applyStimulus(1'b0, 4'h0, 32'h0000_0100, 32'h0);
        idle(5);

        $display("[TB] byte write merge");
        applyStimulus(1'b1, 4'hF,    32'h0000_0200, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 4'b0100, 32'h0000_0200, 32'h00AA_0000);
        applyStimulus(1'b0, 4'h0,    32'h0000_0200, 32'h0);
        idle(5);

        $display("[TB] back-to-back requests against MAX_OUT");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'h0, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200, 32'h0);
        end
        idle(5);

        $display("[TB] reset with reads in flight");
        applyStimulus(1'b0, 4'h0, 32'h0000_0100, 32'h0);
        applyStimulus(1'b0, 4'h0, 32'h0000_0200, 32'h0);
        data_req = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic        wr;
            logic [3:0]  strb;
            logic [31:0] addr;
            wr   = 1'($urandom_range(0, 1));
            strb = 4'($urandom_range(1, 15));
            addr = 32'h0000_0400 + 32'($urandom_range(0, 15)) * 4;
            applyStimulus(wr, strb, addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
        end
        idle(RESP_LAT + 5);
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
